hd_frame_ctrl: RTL and testbench
================================

# hd_frame_ctrl

Frame-level Hamming-distance controller that sits directly upstream of the 16-bit popcount unit (`HammingWeight`) and drives its start/data inputs. It accepts word pairs over a valid/ready handshake and sends each XOR to the popcount unit. It accumulates the returned weights into a saturating per-frame distance and presents the result, with a threshold-match flag, on an output valid/ready handshake.

## Interface
- `FRAME_LEN`, default 8: maximum words per frame; frame closes on the FRAME_LEN-th accepted word or on `in_last`.
- `ACC_W`, default 8: accumulator and threshold width.
- `CNT_W`, default $clog2(FRAME_LEN+1): word-count width.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input pair valid.
- `in_ready`  out  1  block can accept a pair.
- `in_a`, `in_b`  in  16 each  operand words.
- `in_last`  in  1  final word of the frame.
- `thresh`  in  ACC_W  match threshold, sampled on the first accepted word of each frame.
- `hw_start`  out  1  one-cycle start pulse to the popcount unit (`op_start`).
- `hw_din`  out  16  registered `in_a ^ in_b`, to the popcount unit (`din`).
- `hw_vld`  in  1  popcount unit idle/result valid.
- `hw_weight`  in  5  popcount result (0..16).
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_dist`  out  ACC_W  accumulated distance for the frame.
- `out_match`  out  1  `out_dist <= thresh_q`.
- `out_words`  out  CNT_W  number of words in the frame.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: register `hw_din <= in_a^in_b` and `last_q <= in_last | (cnt+1==FRAME_LEN)`, then increment `cnt`.
  - If `cnt`==0, also capture `thresh_q` and clear `acc`.
  - Next state: ISSUE.
- **ISSUE**
  - `hw_start`=`hw_vld`; hold in ISSUE while `hw_vld`=0.
  - When `hw_start` is issued, go to WAIT and set `skip`=1.
- **WAIT**
  - First cycle (`skip`=1): ignore `hw_vld` and clear `skip`.
  - Afterwards, on `hw_vld`=1: `acc <= sat(acc + hw_weight)`.
  - Next state: DONE if `last_q`, else IDLE.
- **DONE**
  - `out_valid`=1 and `in_ready`=0.
  - Outputs are held stable until `out_ready`.
  - On `out_valid & out_ready`: clear `cnt`, go to IDLE.
- **Arithmetic**
  - `hw_weight` is zero-extended to ACC_W.
  - The sum saturates at 2^ACC_W−1; no wrap.
  - `out_match` is combinational from the registered `acc` and `thresh_q`.
- `hw_din` stays constant from capture until the next accept; the popcount unit samples it in the cycle after `hw_start`.
- **Reset:** `rst`=1 forces IDLE, and `acc`, `cnt`, `thresh_q`, `hw_din`, `last_q`, `skip` all go to 0.
  - Mid-operation reset abandons the frame.
  - A popcount computation still in flight is absorbed because ISSUE waits for `hw_vld`=1.
- **Boundaries**
  - `in_valid` arriving outside IDLE is back-pressured.
  - `in_last` on the first word gives a one-word frame.
  - `in_last` together with the FRAME_LEN-th word closes a single frame.
  - `thresh` changes mid-frame are ignored.

## Timing
- **Reset values:** `in_ready`=0 during reset and 1 in the cycle after. `hw_start`=0, `hw_din`=0, `out_valid`=0, `out_dist`=0, `out_match`=1 (0<=0), `out_words`=0.
- **Per-word latency, with the popcount unit idle and the accept at cycle t:**
  - t+1: ISSUE, `hw_start`=1.
  - t+2: WAIT (skip).
  - t+6: `hw_vld`=1 and the accumulate.
  - t+7: IDLE again, or DONE with `out_valid`=1.
- Throughput is one word per 7 cycles.
- `out_ready` held high gives a single-cycle `out_valid` pulse; IDLE follows in the next cycle.
- `hw_start` is never asserted while `hw_vld`=0, and is never high for two consecutive cycles.

## Structure
- **Package `hd_pkg`:**
  - state enum `hd_state_t`
  - `HD_WORD_W`=16, `HD_POP_W`=5
  - saturating-add function `hd_sat_add`
- No sub-module. The block is a single FSM plus datapath registers; the popcount unit is instantiated beside it at the next level up, with the reset polarity adapted there.

## Test plan
- **Single-word frame:** `in_a`=16'hFFFF, `in_b`=16'h0000, `in_last`=1, `thresh`=20 → `out_dist`=16, `out_match`=1, `out_words`=1, `out_valid` at accept+7.
- **Full frame without `in_last`:** FRAME_LEN=8, each pair XOR = 16'h00FF, `thresh`=63 → `out_dist`=64, `out_match`=0, `out_words`=8.
- **Saturation:** ACC_W=5, four words of XOR 16'hFFFF → `out_dist`=31 (not 0), `out_match` per `thresh`.
- **Back-pressure:** hold `out_ready`=0 for 10 cycles in DONE → `out_valid`, `out_dist`, `out_match`, `out_words` stable and `in_ready`=0 throughout. Release → IDLE next cycle, and the next frame starts with `acc`=0.
- **Reset in WAIT:** assert `rst` for one cycle while the popcount unit is mid-calculation → outputs return to reset values. A new word is issued only once `hw_vld`=1, and its distance is correct: 16'hAAAA ^ 16'h0000 → 8.
- **Threshold sampling:** `thresh`=5 at the first word, changed to 0 mid-frame, total 5 → `out_match`=1.

Source files
------------

// File: rtl/hd_frame_ctrl_pkg.sv
// Shared types, widths and arithmetic for the frame-level Hamming-distance controller.
package hd_pkg;

  localparam int HD_WORD_W = 16;
  localparam int HD_POP_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } hd_state_t;

  // Adds a popcount result to an accumulator of width acc_w (1..32), clamping at all-ones.
  function automatic logic [31:0] hd_sat_add(input logic [31:0]         acc,
                                             input logic [HD_POP_W-1:0] weight,
                                             input int unsigned         acc_w);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, acc} + 33'(weight);
    max_val = (33'd1 << acc_w) - 33'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/hd_frame_ctrl.sv
// Feeds XORed word pairs to an external popcount unit and accumulates a saturating
// per-frame Hamming distance, reported with a threshold-match flag.
import hd_pkg::*;

module hd_frame_ctrl #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HD_WORD_W-1:0] in_a,
  input  logic [HD_WORD_W-1:0] in_b,
  input  logic                 in_last,
  input  logic [ACC_W-1:0]     thresh,
  output logic                 hw_start,
  output logic [HD_WORD_W-1:0] hw_din,
  input  logic                 hw_vld,
  input  logic [HD_POP_W-1:0]  hw_weight,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_dist,
  output logic                 out_match,
  output logic [CNT_W-1:0]     out_words
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  hd_state_t        state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] thresh_q;
  logic [CNT_W-1:0] cnt;
  logic             last_q;
  logic             skip;

  // Gated by rst so no pair is accepted in a cycle that is being reset.
  assign in_ready  = (state == ST_IDLE) && !rst;
  // A start is only ever issued while the popcount unit reports idle.
  assign hw_start  = (state == ST_ISSUE) && hw_vld;
  assign out_valid = (state == ST_DONE);
  assign out_dist  = acc;
  assign out_match = (acc <= thresh_q);
  assign out_words = cnt;

  // NOTE: every state register here uses <= so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      cnt      <= '0;
      thresh_q <= '0;
      hw_din   <= '0;
      last_q   <= 1'b0;
      skip     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            hw_din <= in_a ^ in_b;
            last_q <= in_last || (cnt == LAST_IDX);
            cnt    <= cnt + CNT_W'(1);
            if (cnt == '0) begin
              thresh_q <= thresh;
              acc      <= '0;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (hw_vld) begin
            skip  <= 1'b1;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // hw_vld may still read as idle in the cycle right after the start pulse.
          if (skip) begin
            skip <= 1'b0;
          end else if (hw_vld) begin
            acc   <= ACC_W'(hd_sat_add(32'(acc), hw_weight, ACC_W));
            state <= last_q ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_frame_ctrl.sv
// Drives two controllers (ACC_W 8 and 5) in lockstep against a frame-level reference model,
// with a small behavioural popcount unit beside each.
module tb_hd_frame_ctrl;

  localparam int FRAME_LEN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [7:0]  thresh = '0;

  logic [1:0]  in_ready, hw_start, hw_vld, out_valid, out_match;
  logic [15:0] hw_din [2];
  logic [7:0]  dist_m;
  logic [4:0]  dist_s;
  logic [3:0]  words_m, words_s;

  int          pop_cnt [2] = '{0, 0};
  logic [4:0]  pop_w [2] = '{5'd0, 5'd0};
  logic [1:0]  prev_start = 2'b00;
  logic        mon_viol = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          m_cnt = 0;
  int          m_sum = 0;
  logic [7:0]  m_th = '0;
  bit          bp = 1'b0;
  bit          chk_lat = 1'b1;

  always #5 clk = ~clk;

  hd_frame_ctrl u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .thresh(thresh),
    .hw_start(hw_start[0]), .hw_din(hw_din[0]), .hw_vld(hw_vld[0]), .hw_weight(pop_w[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_dist(dist_m),
    .out_match(out_match[0]), .out_words(words_m)
  );

  hd_frame_ctrl #(.ACC_W(5)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .thresh(thresh[4:0]),
    .hw_start(hw_start[1]), .hw_din(hw_din[1]), .hw_vld(hw_vld[1]), .hw_weight(pop_w[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_dist(dist_s),
    .out_match(out_match[1]), .out_words(words_s)
  );

  assign hw_vld[0] = (pop_cnt[0] == 0);
  assign hw_vld[1] = (pop_cnt[1] == 0);

  // Popcount unit: samples din the cycle after start, result valid four cycles later.
  // It is deliberately not reset, so an in-flight computation survives a controller reset.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (hw_start[i] && (!hw_vld[i] || prev_start[i])) mon_viol <= 1'b1;
      if (pop_cnt[i] == 0) begin
        if (hw_start[i]) pop_cnt[i] <= 4;
      end else begin
        if (pop_cnt[i] == 4) pop_w[i] <= 5'($countones(hw_din[i]));
        pop_cnt[i] <= pop_cnt[i] - 1;
      end
    end
    prev_start <= hw_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic await_result();
    int waited = 0;
    int em = (m_sum > 255) ? 255 : m_sum;
    int es = (m_sum > 31) ? 31 : m_sum;
    while (!out_valid[0] && waited < 60) begin
      tick();
      waited++;
    end
    check("out_valid", out_valid[0], 1);
    if (chk_lat) check("latency", cyc - acc_cyc, 6);
    check("dist_m", dist_m, em);
    check("match_m", out_match[0], (em <= int'(m_th)));
    check("words_m", words_m, m_cnt);
    check("valid_s", out_valid[1], 1);
    check("dist_s", dist_s, es);
    check("match_s", out_match[1], (es <= int'(m_th[4:0])));
    check("words_s", words_s, m_cnt);
    check("ready_in_done", in_ready[0], 0);
    if (bp) begin
      for (int k = 0; k < 10; k++) begin
        tick();
        check("bp_valid", out_valid[0], 1);
        check("bp_dist", dist_m, em);
        check("bp_match", out_match[0], (em <= int'(m_th)));
        check("bp_words", words_m, m_cnt);
        check("bp_ready", in_ready[0], 0);
      end
      out_ready = 1'b1;
    end
    tick();
    check("valid_pulse", out_valid[0], 0);
    check("ready_after", in_ready[0], 1);
    m_cnt = 0;
    m_sum = 0;
  endtask

  task automatic send_word(input logic [15:0] a, input logic [15:0] b,
                           input logic last, input logic [7:0] th);
    int waited = 0;
    in_a = a;
    in_b = b;
    in_last = last;
    thresh = th;
    in_valid = 1'b1;
    while (!in_ready[0] && waited < 50) begin
      tick();
      waited++;
    end
    check("in_ready_wait", in_ready[0], 1);
    tick();
    in_valid = 1'b0;
    acc_cyc = cyc;
    if (chk_lat) begin
      check("hw_start_t1", hw_start[0], 1);
      check("hw_din", hw_din[0], a ^ b);
    end else begin
      check("hw_start_gated", hw_start[0], hw_vld[0]);
    end
    if (m_cnt == 0) m_th = th;
    m_sum += $countones(a ^ b);
    m_cnt++;
    if (last || m_cnt == FRAME_LEN) await_result();
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    int          mode;

    repeat (3) tick();
    check("rst_in_ready", in_ready[0], 0);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_dist", dist_m, 0);
    check("rst_match", out_match[0], 1);
    check("rst_words", words_m, 0);
    check("rst_hw_start", hw_start[0], 0);
    check("rst_hw_din", hw_din[0], 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready[0], 1);

    // Single-word frame.
    send_word(16'hFFFF, 16'h0000, 1'b1, 8'd20);

    // Full frame closed by count alone.
    for (int i = 0; i < FRAME_LEN; i++) begin
      a = 16'($urandom);
      send_word(a, a ^ 16'h00FF, 1'b0, 8'd63);
    end

    // in_last coinciding with the last counted word, then an independent frame.
    for (int i = 0; i < FRAME_LEN; i++) begin
      a = 16'($urandom);
      send_word(a, a ^ 16'h0F0F, (i == FRAME_LEN - 1), 8'd70);
    end
    send_word(16'h0001, 16'h0000, 1'b1, 8'd0);

    // Saturation on the narrow instance.
    for (int i = 0; i < 4; i++) send_word(16'hFFFF, 16'h0000, (i == 3), 8'd10);

    // Threshold sampled only on the first word.
    send_word(16'h0007, 16'h0000, 1'b0, 8'd5);
    send_word(16'h0003, 16'h0000, 1'b1, 8'd0);

    // Back-pressure in DONE, then a fresh frame must start from zero.
    out_ready = 1'b0;
    bp = 1'b1;
    send_word(16'h1234, 16'h4321, 1'b0, 8'd9);
    send_word(16'hF0F0, 16'h0000, 1'b1, 8'd200);
    bp = 1'b0;
    send_word(16'h0003, 16'h0000, 1'b1, 8'd2);

    // Reset while the popcount unit is mid-calculation.
    chk_lat = 1'b0;
    send_word(16'hFFFF, 16'h0000, 1'b0, 8'd50);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cnt = 0;
    m_sum = 0;
    #1;
    check("wrst_in_ready", in_ready[0], 1);
    check("wrst_out_valid", out_valid[0], 0);
    check("wrst_dist", dist_m, 0);
    check("wrst_match", out_match[0], 1);
    check("wrst_words", words_m, 0);
    check("wrst_hw_din", hw_din[0], 0);
    check("wrst_busy", hw_vld[0], 0);
    send_word(16'hAAAA, 16'h0000, 1'b1, 8'd10);
    chk_lat = 1'b1;

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      do begin
        mode = int'($urandom_range(0, 2));
        a = 16'($urandom);
        b = (mode == 0) ? 16'($urandom) : (mode == 1) ? ~a : a;
        send_word(a, b, ($urandom_range(0, 4) == 0), 8'($urandom));
      end while (m_cnt != 0);
    end

    check("hw_start_protocol", mon_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
